cpu_seq_ctrl: RTL and testbench

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

---
 rtl/cpu_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for a 16-bit accumulator-style core: steps each instruction through
// fetch/decode/execute/memory/writeback and counts retired instructions.
module cpu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        mem_ready,
    output logic        mem_re,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src,
    output logic        imm_sel,
    output logic        alu_mux_cntrl,
    output logic        reg_we,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [3:0] OpAluReg = 4'h0;
    localparam logic [3:0] OpAluImm = 4'h1;
    localparam logic [3:0] OpLoad   = 4'h4;
    localparam logic [3:0] OpStor   = 4'h5;
    localparam logic [3:0] OpBrz    = 4'hC;
    localparam logic [3:0] OpNop    = 4'hE;
    localparam logic [3:0] OpHalt   = 4'hF;

    state_e      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic [3:0] opcode;
    logic       is_alu, is_load, is_stor, is_brz, is_nop, is_halt, needs_exec, uses_imm;
    logic       retire;

    // Operand fields are decoded by the datapath, not here.
    logic       unused_operand;

    assign opcode         = instr[15:12];
    assign unused_operand = ^instr[11:0];

    assign is_alu     = (opcode == OpAluReg) || (opcode == OpAluImm);
    assign is_load    = (opcode == OpLoad);
    assign is_stor    = (opcode == OpStor);
    assign is_brz     = (opcode == OpBrz);
    assign is_nop     = (opcode == OpNop);
    assign is_halt    = (opcode == OpHalt);
    assign needs_exec = is_alu || is_load || is_stor || is_brz;
    assign uses_imm   = (opcode == OpAluImm) || is_load || is_stor;

    always_comb begin
        state_d       = state_q;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        imm_sel       = 1'b0;
        alu_mux_cntrl = 1'b0;
        reg_we        = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;

        case (state_q)
            StFetch: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (needs_exec) begin
                    state_d = StExec;
                end else if (is_nop) begin
                    state_d = StFetch;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    illegal = 1'b1;
                    state_d = StFetch;
                end
            end
            StExec: begin
                imm_sel = uses_imm;
                if (is_alu) begin
                    state_d = StWb;
                end else if (is_load || is_stor) begin
                    state_d = StMem;
                end else begin
                    if (is_brz && flag_z) begin
                        pc_en  = 1'b1;
                        pc_src = 1'b1;
                    end
                    state_d = StFetch;
                end
            end
            StMem: begin
                mem_re        = is_load;
                mem_we        = is_stor;
                alu_mux_cntrl = is_load;
                // An opcode that is neither load nor store cannot wait on memory; retire it.
                if (!(is_load || is_stor)) begin
                    state_d = StFetch;
                end else if (mem_ready) begin
                    state_d = is_load ? StWb : StFetch;
                end
            end
            StWb: begin
                reg_we        = 1'b1;
                alu_mux_cntrl = is_load;
                state_d       = StFetch;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (reset) begin
            mem_re        = 1'b0;
            mem_we        = 1'b0;
            ir_load       = 1'b0;
            pc_en         = 1'b0;
            pc_src        = 1'b0;
            imm_sel       = 1'b0;
            alu_mux_cntrl = 1'b0;
            reg_we        = 1'b0;
            illegal       = 1'b0;
            halted        = 1'b0;
        end
    end

    // One retirement per instruction: on its return to fetch, or on entering halt.
    always_comb begin
        retire = 1'b0;
        if (state_d == StFetch) begin
            retire = (state_q == StDecode) || (state_q == StExec) ||
                     (state_q == StMem) || (state_q == StWb);
        end else if (state_d == StHalt) begin
            retire = (state_q != StHalt);
        end
        instr_count_d = instr_count_q + {15'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch;
            instr_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomised self-checking bench for cpu_seq_ctrl: each instruction is expanded into its expected
// per-cycle output trace from the opcode rules and compared cycle by cycle.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        flag_z = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_re, mem_we, ir_load, pc_en, pc_src, imm_sel, alu_mux_cntrl;
    logic        reg_we, illegal, halted;
    logic [2:0]  state;
    logic [15:0] instr_count;

    logic [12:0] act;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_cnt = 16'h0000;

    typedef struct packed {
        logic        rdy;
        logic        inc;
        logic [12:0] exp;
    } cyc_t;

    cpu_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .flag_z        (flag_z),
        .mem_ready     (mem_ready),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .ir_load       (ir_load),
        .pc_en         (pc_en),
        .pc_src        (pc_src),
        .imm_sel       (imm_sel),
        .alu_mux_cntrl (alu_mux_cntrl),
        .reg_we        (reg_we),
        .illegal       (illegal),
        .halted        (halted),
        .state         (state),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    assign act = {state, mem_re, mem_we, ir_load, pc_en, pc_src, imm_sel, alu_mux_cntrl,
                  reg_we, illegal, halted};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] mk(input logic [2:0] st, input logic re, we, irl, pce, pcs,
                                       imm, amux, rwe, ill, hlt);
        return {st, re, we, irl, pce, pcs, imm, amux, rwe, ill, hlt};
    endfunction

    // Expand one instruction into its expected cycle trace, then drive and check it.
    task automatic run_instr(input logic [15:0] ins, input logic fz, input int fstall,
                             input int mstall, input int hcyc, input string tag);
        cyc_t q[$];
        logic [3:0] op;
        logic ld, st, alu, brz, legal, ill, br;
        op    = ins[15:12];
        ld    = (op == 4'h4);
        st    = (op == 4'h5);
        alu   = (op == 4'h0) || (op == 4'h1);
        brz   = (op == 4'hC);
        legal = alu || ld || st || brz;
        ill   = !legal && (op != 4'hE) && (op != 4'hF);
        br    = brz && fz;
        for (int i = 0; i < fstall; i++)
            q.push_back(cyc_t'{1'b0, 1'b0, mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back(cyc_t'{1'b1, 1'b0, mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0)});
        q.push_back(cyc_t'{1'($urandom), !legal, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, ill, 0)});
        if (legal)
            q.push_back(cyc_t'{1'($urandom), brz,
                               mk(3'd2, 0, 0, 0, br, br, (op == 4'h1) || ld || st, 0, 0, 0, 0)});
        if (ld || st) begin
            for (int i = 0; i < mstall; i++)
                q.push_back(cyc_t'{1'b0, 1'b0, mk(3'd3, ld, st, 0, 0, 0, 0, ld, 0, 0, 0)});
            q.push_back(cyc_t'{1'b1, st, mk(3'd3, ld, st, 0, 0, 0, 0, ld, 0, 0, 0)});
        end
        if (alu || ld)
            q.push_back(cyc_t'{1'($urandom), 1'b1, mk(3'd4, 0, 0, 0, 0, 0, 0, ld, 1, 0, 0)});
        if (op == 4'hF)
            for (int i = 0; i < hcyc; i++)
                q.push_back(cyc_t'{1'($urandom), 1'b0, mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});

        foreach (q[i]) begin
            @(negedge clk);
            // Instruction register contents are don't-care during fetch.
            instr     = (q[i].exp[12:10] == 3'd0) ? 16'($urandom) : ins;
            mem_ready = q[i].rdy;
            flag_z    = fz;
            #1;
            tests++;
            if (act !== q[i].exp) begin
                fails++;
                $display("FAIL %s instr=%h cycle %0d outputs: got %b expected %b",
                         tag, ins, i, act, q[i].exp);
            end
            tests++;
            if (instr_count !== model_cnt) begin
                fails++;
                $display("FAIL %s instr=%h cycle %0d instr_count: got %h expected %h",
                         tag, ins, i, instr_count, model_cnt);
            end
            model_cnt = model_cnt + {15'd0, q[i].inc};
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        flag_z    = 1'b1;
        instr     = 16'($urandom);
        #1;
        tests++;
        if (act[9:0] !== 10'b0) begin
            fails++;
            $display("FAIL %s outputs during reset: got %b expected 0", tag, act[9:0]);
        end
        @(negedge clk);
        #1;
        tests++;
        if (state !== 3'd0 || instr_count !== 16'h0000 || act[9:0] !== 10'b0) begin
            fails++;
            $display("FAIL %s reset state/count: got state=%0d count=%h outs=%b expected 0/0/0",
                     tag, state, instr_count, act[9:0]);
        end
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        tests++;
        if (act !== mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            fails++;
            $display("FAIL %s first fetch after reset: got %b expected mem_re only", tag, act);
        end
        model_cnt = 16'h0000;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_alu();
        run_instr(16'h0123, 1'b0, 0, 0, 0, "alu_reg");
        run_instr(16'h1abc, 1'b1, 1, 0, 0, "alu_imm");
    endtask

    task automatic test_load();
        run_instr(16'h4321, 1'b0, 0, 3, 0, "load_stall");
        run_instr(16'h4000, 1'b1, 0, 0, 0, "load_fast");
    endtask

    task automatic test_stor();
        run_instr(16'h5a5a, 1'b0, 0, 0, 0, "stor");
        run_instr(16'h5fff, 1'b1, 2, 2, 0, "stor_stall");
    endtask

    task automatic test_brz();
        run_instr(16'hc010, 1'b1, 0, 0, 0, "brz_taken");
        run_instr(16'hc010, 1'b0, 0, 0, 0, "brz_not_taken");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF) op = 4'hE;
            run_instr({op, 12'($urandom)}, 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), 0, "random");
        end
    endtask

    task automatic test_reset_in_mem();
        @(negedge clk);
        instr     = 16'h4abc;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (state !== 3'd3 || mem_re !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_mem reach MEM: got state=%0d mem_re=%b expected 3/1",
                     state, mem_re);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (act[9:0] !== 10'b0) begin
            fails++;
            $display("FAIL reset_in_mem outputs: got %b expected 0", act[9:0]);
        end
        @(negedge clk);
        #1;
        tests++;
        if (state !== 3'd0 || instr_count !== 16'h0000) begin
            fails++;
            $display("FAIL reset_in_mem state/count: got %0d/%h expected 0/0000",
                     state, instr_count);
        end
        reset     = 1'b0;
        mem_ready = 1'b0;
        model_cnt = 16'h0000;
    endtask

    task automatic test_illegal_halt();
        run_instr(16'h7123, 1'b0, 0, 0, 0, "illegal");
        run_instr(16'hf000, 1'b1, 0, 0, 4, "halt");
        tests++;
        if (instr_count !== 16'h0002) begin
            fails++;
            $display("FAIL halt_count: got %h expected 0002", instr_count);
        end
        do_reset("reset_from_halt");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.instr_count_q = 16'hff00;
        @(posedge clk);
        #1;
        release dut.instr_count_q;
        model_cnt = 16'hff00;
        for (int n = 0; n < 255; n++)
            run_instr({4'hE, 12'($urandom)}, 1'($urandom), 0, 0, 0, "nop_loop");
        run_instr(16'he000, 1'b0, 0, 0, 0, "nop_wrap");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
        if (instr_count !== 16'h0000) begin
            fails++;
            $display("FAIL wrap: got instr_count=%h expected 0000", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_stor();
        test_brz();
        test_random();
        test_reset_in_mem();
        test_illegal_halt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
